dmem_bus_bridge: RTL
====================

DMEM_BUS_BRIDGE -- requirements
Module: dmem_bus_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum bus wait cycles before the access is aborted (range 1..255).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 addr  in  32  core data address (ALU result).
REQ-005 wdata  in  32  core store data (rs2).
REQ-006 wen  in  2  store type: 00 none, 01 SB, 10 SH, 11 SW.
REQ-007 ren  in  1  load request from the core.
REQ-008 rdata  out  32  load data to the core, right-aligned by addr[1:0].
REQ-009 stall  out  1  holds the core PC and instruction while high.
REQ-010 err  out  1  access fault; valid in the DONE cycle only.
REQ-011 bus_req  out  1  bus transaction request.
REQ-012 bus_we  out  1  1 = write, 0 = read.
REQ-013 bus_addr  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-014 bus_wdata  out  32  lane-replicated store data.
REQ-015 bus_strb  out  4  byte-lane write strobes; 0000 on reads.
REQ-016 bus_ready  in  1  slave completes the transaction in this cycle.
REQ-017 bus_rdata  in  32  read data; sampled only when bus_ready=1.
REQ-018 bus_err  in  1  slave error; sampled only when bus_ready=1.

Function
REQ-019 The FSM SHALL have three states: IDLE, REQ, DONE.
REQ-020 Access is active when wen!=00 or ren=1; wen!=00 SHALL take priority, so the access is a store and ren is ignored.
REQ-021 In IDLE with an active access, stall SHALL be 1 combinationally, and addr, wdata, wen and the access type SHALL be captured at the next edge.
REQ-022 A misaligned access (SH/LH with addr[0]=1, SW/LW with addr[1:0]!=00) SHALL go IDLE->DONE with err=1, issue no bus transaction, and suppress the store.
REQ-023 An aligned access SHALL go IDLE->REQ; bus_req SHALL be 1 for every REQ cycle, and bus_addr, bus_we, bus_wdata and bus_strb SHALL be driven from the captured registers and stay stable until bus_ready.
REQ-024 Strobes: SB gives 0001<<addr[1:0]; SH gives 0011<<{addr[1],1'b0}; SW gives 1111.
REQ-025 bus_wdata: SB gives {4{wdata[7:0]}}; SH gives {2{wdata[15:0]}}; SW gives wdata.
REQ-026 In REQ with bus_ready=1, the FSM SHALL go to DONE; on a read it SHALL latch rdata = bus_rdata >> (8*addr[1:0]), and err SHALL latch bus_err.
REQ-027 A wait counter SHALL clear on REQ entry and increment each REQ cycle without bus_ready.
REQ-028 When the counter reaches TIMEOUT, the FSM SHALL go to DONE with err=1, rdata=0 and bus_req dropped.
REQ-029 DONE SHALL last exactly one cycle with stall=0, so the core retires the instruction at that edge; the next state is always IDLE.
REQ-030 The DONE->IDLE->next-access sequence SHALL NOT re-capture the retired access; a new access is accepted only from IDLE.
REQ-031 With no access in IDLE, stall=0, bus_req=0, and rdata/err SHALL hold their last values.
REQ-032 Latency: an aligned access with bus_ready in the first REQ cycle stalls for 2 cycles (IDLE, REQ) and retires in DONE.
REQ-033 bus_ready while not in REQ SHALL be ignored.

Reset
REQ-034 rst=1 SHALL force IDLE immediately, mid-transaction included.
REQ-035 On reset, bus_req=0, bus_we=0, bus_strb=0000, stall=0, err=0, rdata=0, bus_addr=0, bus_wdata=0 and the counter=0.
REQ-036 Release of rst SHALL start no transaction until the next active access is seen in IDLE.

Verification
REQ-037 Store: SB addr=0x1003 wdata=0xAB, bus_ready on the first REQ cycle -> bus_addr=0x1000, strb=1000, bus_wdata=0xABABABAB, stall high for 2 cycles, err=0.
REQ-038 Load: LW addr=0x2000, bus_ready after 3 wait cycles, bus_rdata=0xDEADBEEF -> rdata=0xDEADBEEF in DONE, stall high for 5 cycles.
REQ-039 Misaligned SW at addr=0x0002 -> no bus_req, err=1 in DONE, stall high for 1 cycle.
REQ-040 Timeout: TIMEOUT=4 with bus_ready never asserted -> DONE after 4 REQ cycles, err=1, rdata=0.
REQ-041 Simultaneous wen=11 and ren=1 -> write transaction only (bus_we=1); rst asserted mid-REQ -> bus_req=0 the same cycle and state IDLE.
REQ-042 Back-to-back: LH addr=0x3002 then SW -> rdata = bus_rdata>>16, then exactly one write transaction with no duplicate capture.

Source files
------------

// File: rtl/dmem_bus_bridge.sv
// Data-memory bridge: turns core load/store requests into single-beat bus
// transactions, stalling the core until the access retires in DONE.
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_strb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_addr_lo;
  logic             r_store;
  logic [31:0]      r_rdata;
  logic             r_err;
  logic             r_bus_req;
  logic             r_bus_we;
  logic [31:0]      r_bus_addr;
  logic [31:0]      r_bus_wdata;
  logic [3:0]       r_bus_strb;

  logic             w_active;
  logic             w_store;
  logic             w_misaligned;
  logic [3:0]       w_strb;
  logic [31:0]      w_wdata_rep;
  logic [31:0]      w_rdata_shift;

  // A store wins over a simultaneous load request.
  assign w_store  = (wen != 2'b00);
  assign w_active = w_store || ren;

  // Loads carry no size, so they are full-word reads and can never be misaligned;
  // the core extracts and extends the right-aligned bytes itself.
  assign w_misaligned = ((wen == 2'b10) && addr[0]) ||
                        ((wen == 2'b11) && (addr[1:0] != 2'b00));

  always_comb begin
    w_strb      = 4'b0000;
    w_wdata_rep = 32'h0000_0000;
    case (wen)
      2'b01: begin
        w_strb      = 4'b0001 << addr[1:0];
        w_wdata_rep = {4{wdata[7:0]}};
      end
      2'b10: begin
        w_strb      = 4'b0011 << {addr[1], 1'b0};
        w_wdata_rep = {2{wdata[15:0]}};
      end
      2'b11: begin
        w_strb      = 4'b1111;
        w_wdata_rep = wdata;
      end
      default: ;
    endcase
  end

  assign w_rdata_shift = bus_rdata >> {r_addr_lo, 3'b000};

  // Stall is combinational in IDLE so the core freezes in the same cycle it asks.
  assign stall = !rst && ((r_state == S_REQ) || ((r_state == S_IDLE) && w_active));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr_lo   <= 2'b00;
      r_store     <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_strb  <= 4'b0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_active) begin
            r_addr_lo <= addr[1:0];
            r_store   <= w_store;
            if (w_misaligned) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state     <= S_REQ;
              r_cnt       <= '0;
              r_bus_req   <= 1'b1;
              r_bus_we    <= w_store;
              r_bus_addr  <= {addr[31:2], 2'b00};
              r_bus_wdata <= w_wdata_rep;
              r_bus_strb  <= w_strb;
            end
          end
        end
        S_REQ: begin
          if (bus_ready) begin
            r_state   <= S_DONE;
            r_bus_req <= 1'b0;
            r_err     <= bus_err;
            if (!r_store) begin
              r_rdata <= w_rdata_shift;
            end
          end else if (r_cnt == CNT_LAST) begin
            // Slave never answered: abort with a fault and no data.
            r_state   <= S_DONE;
            r_bus_req <= 1'b0;
            r_err     <= 1'b1;
            r_rdata   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rdata     = r_rdata;
  assign err       = r_err;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_strb  = r_bus_strb;

endmodule
